// File: rtl/modport_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, one clock.
// Optional RAM_WRITE_FIRST_EN: a same-address collision bypasses wr_data to rd_data.
module modport_ram #(
   parameter int ADDR_WIDTH = 4,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_enb,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_enb,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;

   // NOTE: rd_word gets its default first so no path through the block leaves it unassigned (no latch).
   always_comb begin
      rd_word = mem[rd_addr];
`ifdef RAM_WRITE_FIRST_EN
      if (wr_enb && (wr_addr == rd_addr)) begin
         rd_word = wr_data;
      end
`endif
   end

   // NOTE: the storage array is cleared by reset because a zeroed memory after rst is part of the
   // block's contract; this rules out block-RAM inference, which is accepted at this depth.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (wr_enb) begin
         mem[wr_addr] <= wr_data;
      end
   end

   // NOTE: non-blocking assignments keep the read of mem[] on the old word when the same edge writes it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_enb;
         if (rd_enb) begin
            rd_data <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_modport_ram.sv
// Self-checking bench for modport_ram: directed scenarios plus randomized traffic against an array model.
module tb_modport_ram;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 2 ** AW;
`ifdef RAM_WRITE_FIRST_EN
   localparam bit WRITE_FIRST = 1'b1;
`else
   localparam bit WRITE_FIRST = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          clk_run = 1'b1;
   logic          rst = 1'b1;
   logic          wr_enb = 1'b0;
   logic [AW-1:0] wr_addr = '0;
   logic [DW-1:0] wr_data = '0;
   logic          rd_enb = 1'b0;
   logic [AW-1:0] rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          rd_valid;

   int passed = 0;
   int total  = 0;

   // Reference model: plain array plus the expected output pair.
   logic [DW-1:0] model_mem [DEPTH];
   logic [DW-1:0] exp_data;
   logic          exp_valid;

   modport_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk      (clk),
      .rst      (rst),
      .wr_enb   (wr_enb),
      .wr_addr  (wr_addr),
      .wr_data  (wr_data),
      .rd_enb   (rd_enb),
      .rd_addr  (rd_addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid)
   );

   always begin
      #5;
      if (clk_run) clk = ~clk;
   end

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
      exp_data  = '0;
      exp_valid = 1'b0;
   endtask

   // Drive one cycle of traffic, advance past the edge, and update the model.
   task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                     input logic re, input logic [AW-1:0] ra);
      wr_enb = we; wr_addr = wa; wr_data = wd;
      rd_enb = re; rd_addr = ra;
      if (re) begin
         exp_valid = 1'b1;
         exp_data  = (we && wa == ra && WRITE_FIRST) ? wd : model_mem[ra];
      end else begin
         exp_valid = 1'b0;
      end
      if (we) model_mem[wa] = wd;
      @(posedge clk);
      #1;
      wr_enb = 1'b0;
      rd_enb = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      op(1'b1, 4'h0, 8'hC3, 1'b0, 4'h0);
      op(1'b1, 4'hF, 8'h7E, 1'b1, 4'h0);
      total++;
      if (rd_data !== 8'hC3) $display("FAIL reset_pre_read: got %h want %h", rd_data, 8'hC3);
      else passed++;
      // Stop the clock low, then pulse rst between edges.
      @(negedge clk);
      clk_run = 1'b0;
      #3;
      rst = 1'b1;
      #1;
      model_reset();
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b0)
         $display("FAIL reset_async: got data=%h valid=%b want data=00 valid=0", rd_data, rd_valid);
      else passed++;
      #4;
      rst = 1'b0;
      #2;
      clk_run = 1'b1;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h0);
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b1)
         $display("FAIL reset_read_0: got data=%h valid=%b want data=00 valid=1", rd_data, rd_valid);
      else passed++;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'hF);
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b1)
         $display("FAIL reset_read_f: got data=%h valid=%b want data=00 valid=1", rd_data, rd_valid);
      else passed++;
   endtask

   task automatic test_write_read();
      op(1'b1, 4'h3, 8'hA5, 1'b0, 4'h0);
      total++;
      if (rd_valid !== 1'b0) $display("FAIL wr_only_valid: got %b want 0", rd_valid);
      else passed++;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h3);
      total++;
      if (rd_data !== 8'hA5 || rd_valid !== 1'b1)
         $display("FAIL write_read: got data=%h valid=%b want data=a5 valid=1", rd_data, rd_valid);
      else passed++;
      op(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
      total++;
      if (rd_valid !== 1'b0 || rd_data !== 8'hA5)
         $display("FAIL write_read_drop: got data=%h valid=%b want data=a5 valid=0", rd_data, rd_valid);
      else passed++;
   endtask

   task automatic test_sweep();
      int errs = 0;
      for (int a = 0; a < DEPTH; a++) op(1'b1, AW'(a), DW'(a) ^ 8'h5A, 1'b0, 4'h0);
      for (int a = 0; a < DEPTH; a++) begin
         op(1'b0, 4'h0, 8'h00, 1'b1, AW'(a));
         total++;
         if (rd_data !== (DW'(a) ^ 8'h5A) || rd_valid !== 1'b1) begin
            $display("FAIL sweep_%0d: got data=%h valid=%b want data=%h valid=1",
                     a, rd_data, rd_valid, DW'(a) ^ 8'h5A);
            errs++;
         end else passed++;
      end
      op(1'b0, 4'h0, 8'h00, 1'b0, 4'h0);
      total++;
      if (rd_valid !== 1'b0) $display("FAIL sweep_end_valid: got %b want 0", rd_valid);
      else passed++;
   endtask

   task automatic test_collision();
      logic [DW-1:0] want;
      op(1'b1, 4'h7, 8'h11, 1'b0, 4'h0);
      op(1'b1, 4'h7, 8'h22, 1'b1, 4'h7);
      want = WRITE_FIRST ? 8'h22 : 8'h11;
      total++;
      if (rd_data !== want || rd_valid !== 1'b1)
         $display("FAIL collision: got data=%h valid=%b want data=%h valid=1", rd_data, rd_valid, want);
      else passed++;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h7);
      total++;
      if (rd_data !== 8'h22) $display("FAIL collision_after: got %h want 22", rd_data);
      else passed++;
      // Different addresses in the same cycle stay independent.
      op(1'b1, 4'h8, 8'h44, 1'b1, 4'h7);
      total++;
      if (rd_data !== 8'h22) $display("FAIL diff_addr: got %h want 22", rd_data);
      else passed++;
   endtask

   task automatic test_hold();
      op(1'b1, 4'h2, 8'h3C, 1'b0, 4'h0);
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h2);
      for (int i = 0; i < 3; i++) begin
         op(1'b1, 4'h2, 8'h99, 1'b0, 4'h0);
         total++;
         if (rd_data !== 8'h3C || rd_valid !== 1'b0)
            $display("FAIL hold_%0d: got data=%h valid=%b want data=3c valid=0", i, rd_data, rd_valid);
         else passed++;
      end
   endtask

   task automatic test_reset_mid();
      op(1'b1, 4'h4, 8'h55, 1'b0, 4'h0);
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h4);
      // Set up a read of 0x4 and hit rst before its edge.
      rd_enb = 1'b1; rd_addr = 4'h4;
      wr_enb = 1'b1; wr_addr = 4'h9; wr_data = 8'hEE;
      #2;
      rst = 1'b1;
      #1;
      model_reset();
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b0)
         $display("FAIL reset_mid_async: got data=%h valid=%b want data=00 valid=0", rd_data, rd_valid);
      else passed++;
      @(posedge clk);
      #1;
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b0)
         $display("FAIL reset_mid_held: got data=%h valid=%b want data=00 valid=0", rd_data, rd_valid);
      else passed++;
      rd_enb = 1'b0; wr_enb = 1'b0;
      rst = 1'b0;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h4);
      total++;
      if (rd_data !== 8'h00 || rd_valid !== 1'b1)
         $display("FAIL reset_mid_read4: got data=%h valid=%b want data=00 valid=1", rd_data, rd_valid);
      else passed++;
      op(1'b0, 4'h0, 8'h00, 1'b1, 4'h9);
      total++;
      if (rd_data !== 8'h00) $display("FAIL reset_mid_read9: got %h want 00", rd_data);
      else passed++;
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 400; i++) begin
         op(1'($urandom), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
            1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, DEPTH - 1)));
         total++;
         if (rd_data !== exp_data || rd_valid !== exp_valid) begin
            if (errs < 10)
               $display("FAIL random_%0d: got data=%h valid=%b want data=%h valid=%b",
                        i, rd_data, rd_valid, exp_data, exp_valid);
            errs++;
         end else passed++;
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_sweep();
      test_collision();
      test_hold();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
